// File: rtl/nvdla_sdp_pkg.sv
// rtl/nvdla_sdp_pkg.sv - shared SDP Y-core channel constants, payload types and pointer helper
package nvdla_sdp_pkg;

  localparam int SDP_Y_OP_WIDTH = 128;

  typedef logic [SDP_Y_OP_WIDTH-1:0] sdp_y_op_pd_t;

  typedef struct packed {
    logic         vld;
    sdp_y_op_pd_t pd;
  } sdp_y_op_chn_t;

  // Ring-pointer increment for storage depths that need not be a power of two.
  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sdp_y_core_skid_mem.sv
// rtl/sdp_y_core_skid_mem.sv - DEPTH x WIDTH skid storage, one write port, one async read port
module sdp_y_core_skid_mem #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Entries clear on reset so a stale beat can never be observed after a reset.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sdp_y_core_chn_skid_fifo.sv
// rtl/sdp_y_core_chn_skid_fifo.sv - Y-core operand channel skid FIFO with optional bypass and flush
module sdp_y_core_chn_skid_fifo
  import nvdla_sdp_pkg::*;
#(
  parameter int WIDTH  = SDP_Y_OP_WIDTH,
  parameter int DEPTH  = 2,
  parameter int BYPASS = 1
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rstn,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [WIDTH-1:0]           in_pd,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [WIDTH-1:0]           out_pd,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf_err
);

  localparam int   CNT_W = $clog2(DEPTH + 1);
  localparam int   PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic BYP   = (BYPASS != 0);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             stall_q, stall_d;
  logic [WIDTH-1:0] stall_pd_q;
  logic             ovf_q, ovf_d;
  logic             empty, full, acc, deq, push, pop;
  logic [WIDTH-1:0] rd_data;

  // in_rdy depends only on registered occupancy; a full buffer takes a one-cycle bubble.
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign in_rdy  = !full;
  assign out_vld = !empty || (BYP && in_vld);
  assign out_pd  = (BYP && empty) ? in_pd : rd_data;
  assign acc     = in_vld && in_rdy;
  assign deq     = out_vld && out_rdy;
  // A beat consumed straight through the bypass path never occupies storage.
  assign push    = acc && !(BYP && empty && out_rdy);
  assign pop     = deq && !empty;
  assign count   = count_q;
  assign ovf_err = ovf_q;

  sdp_y_core_skid_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .we              (push && !flush),
    .waddr           (wr_ptr_q),
    .wdata           (in_pd),
    .raddr           (rd_ptr_q),
    .rdata           (rd_data)
  );

  // Next-state: flush wins over push/pop; protocol checker watches for payload change under stall.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = PTR_W'(ptr_wrap_inc(32'(wr_ptr_q), DEPTH));
      if (pop)  rd_ptr_d = PTR_W'(ptr_wrap_inc(32'(rd_ptr_q), DEPTH));
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    stall_d = in_vld && !in_rdy;
    ovf_d   = ovf_q || (stall_q && in_vld && (in_pd != stall_pd_q));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      stall_q    <= 1'b0;
      stall_pd_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      stall_q    <= stall_d;
      stall_pd_q <= in_pd;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sdp_y_core_chn_skid_fifo.sv
// tb/tb_sdp_y_core_chn_skid_fifo.sv - self-checking bench for the Y-core channel skid FIFO
module tb_sdp_y_core_chn_skid_fifo;

  logic clk;
  logic rstn;

  // A: BYPASS=1 DEPTH=2 WIDTH=128
  logic         a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_flush, a_ovf;
  logic [127:0] a_in_pd, a_out_pd;
  logic [1:0]   a_count;
  // B: BYPASS=1 DEPTH=3 WIDTH=8
  logic         b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_flush, b_ovf;
  logic [7:0]   b_in_pd, b_out_pd;
  logic [1:0]   b_count;
  // C: BYPASS=0 DEPTH=2 WIDTH=8
  logic         c_in_vld, c_in_rdy, c_out_vld, c_out_rdy, c_flush, c_ovf;
  logic [7:0]   c_in_pd, c_out_pd;
  logic [1:0]   c_count;

  int checks = 0;
  int errors = 0;

  sdp_y_core_chn_skid_fifo #(.WIDTH(128), .DEPTH(2), .BYPASS(1)) dut_a (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_vld(a_in_vld), .in_rdy(a_in_rdy), .in_pd(a_in_pd),
    .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_pd(a_out_pd),
    .flush(a_flush), .count(a_count), .ovf_err(a_ovf));

  sdp_y_core_chn_skid_fifo #(.WIDTH(8), .DEPTH(3), .BYPASS(1)) dut_b (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_pd(b_in_pd),
    .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_pd(b_out_pd),
    .flush(b_flush), .count(b_count), .ovf_err(b_ovf));

  sdp_y_core_chn_skid_fifo #(.WIDTH(8), .DEPTH(2), .BYPASS(0)) dut_c (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_vld(c_in_vld), .in_rdy(c_in_rdy), .in_pd(c_in_pd),
    .out_vld(c_out_vld), .out_rdy(c_out_rdy), .out_pd(c_out_pd),
    .flush(c_flush), .count(c_count), .ovf_err(c_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         vld;
    logic [127:0] pd;
    logic         rdy;
    logic         fl;
    logic         e_irdy;
    logic         e_ovld;
    logic [127:0] e_pd;
    logic [1:0]   e_cnt;
  } vec_t;

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int sent, rx, cyc;
    rstn = 1'b0;
    a_in_vld = 0; a_in_pd = '0; a_out_rdy = 0; a_flush = 0;
    b_in_vld = 0; b_in_pd = '0; b_out_rdy = 0; b_flush = 0;
    c_in_vld = 0; c_in_pd = '0; c_out_rdy = 0; c_flush = 0;

    //              vld  pd        rdy fl   irdy ovld e_pd      cnt
    tbl[0]  = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b0, 128'h0, 2'd0};
    tbl[1]  = '{1'b1, PAT_A5, 1'b1, 1'b0, 1'b1, 1'b1, PAT_A5, 2'd0};
    tbl[2]  = '{1'b1, 128'h1, 1'b0, 1'b0, 1'b1, 1'b1, 128'h1, 2'd0};
    tbl[3]  = '{1'b1, 128'h2, 1'b0, 1'b0, 1'b1, 1'b1, 128'h1, 2'd1};
    tbl[4]  = '{1'b1, 128'h3, 1'b0, 1'b0, 1'b0, 1'b1, 128'h1, 2'd2};
    tbl[5]  = '{1'b1, 128'h3, 1'b1, 1'b0, 1'b0, 1'b1, 128'h1, 2'd2};
    tbl[6]  = '{1'b1, 128'h3, 1'b1, 1'b0, 1'b1, 1'b1, 128'h2, 2'd1};
    tbl[7]  = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b1, 128'h3, 2'd1};
    tbl[8]  = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b0, 128'h0, 2'd0};
    tbl[9]  = '{1'b1, 128'h4, 1'b0, 1'b0, 1'b1, 1'b1, 128'h4, 2'd0};
    tbl[10] = '{1'b1, 128'h5, 1'b0, 1'b0, 1'b1, 1'b1, 128'h4, 2'd1};
    tbl[11] = '{1'b1, 128'h6, 1'b0, 1'b1, 1'b0, 1'b1, 128'h4, 2'd2};
    tbl[12] = '{1'b1, 128'h6, 1'b0, 1'b0, 1'b1, 1'b1, 128'h6, 2'd0};
    tbl[13] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b1, 128'h6, 2'd1};
    tbl[14] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b0, 128'h0, 2'd0};
    tbl[15] = '{1'b1, 128'h7, 1'b1, 1'b1, 1'b1, 1'b1, 128'h7, 2'd0};
    tbl[16] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b0, 128'h0, 2'd0};
    tbl[17] = '{1'b1, 128'h8, 1'b0, 1'b1, 1'b1, 1'b1, 128'h8, 2'd0};
    tbl[18] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 1'b0, 128'h0, 2'd0};

    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("c_reset_out_vld", c_out_vld, 0);
    chk("b_reset_count", b_count, 0);
    chk("a_reset_ovf", a_ovf, 0);

    // Table: bypass, fill/stall/drain order, flush with and without stored beats.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      a_in_vld = tbl[i].vld; a_in_pd = tbl[i].pd; a_out_rdy = tbl[i].rdy; a_flush = tbl[i].fl;
      #1;
      chk($sformatf("v%0d_in_rdy", i), a_in_rdy, tbl[i].e_irdy);
      chk($sformatf("v%0d_out_vld", i), a_out_vld, tbl[i].e_ovld);
      if (tbl[i].e_ovld) chk($sformatf("v%0d_out_pd", i), a_out_pd, tbl[i].e_pd);
      chk($sformatf("v%0d_count", i), a_count, tbl[i].e_cnt);
      chk($sformatf("v%0d_ovf", i), a_ovf, 0);
    end
    @(negedge clk);
    a_in_vld = 0; a_out_rdy = 0; a_flush = 0; a_in_pd = '0;

    // DEPTH=3 wrap with random back-pressure and a strict in-order scoreboard.
    sent = 0; rx = 0;
    for (cyc = 0; cyc < 400 && rx < 10; cyc++) begin
      @(negedge clk);
      b_in_vld = (sent < 10);
      b_in_pd = 8'(8'h10 + sent);
      b_out_rdy = 1'($urandom_range(0, 1));
      #1;
      chk("b_count_le3", (b_count <= 2'd3 && b_count != 2'd0) || b_count == 2'd0 ? 1 : 0, 1);
      if (b_out_vld && b_out_rdy) begin
        chk($sformatf("b_rx%0d_pd", rx), b_out_pd, 8'(8'h10 + rx));
        rx++;
      end
      if (b_in_vld && b_in_rdy) sent++;
    end
    chk("b_all_received", rx, 10);
    chk("b_ovf_clean", b_ovf, 0);
    @(negedge clk);
    b_in_vld = 0; b_out_rdy = 0;
    #1;
    chk("b_drained", b_count, 0);

    // BYPASS=0: beat appears one cycle after acceptance.
    @(negedge clk);
    c_in_vld = 1; c_in_pd = 8'h5C; c_out_rdy = 1;
    #1;
    chk("c_accept_in_rdy", c_in_rdy, 1);
    chk("c_no_same_cycle_out", c_out_vld, 0);
    @(negedge clk);
    c_in_vld = 0; c_in_pd = 8'h00;
    #1;
    chk("c_out_vld_next", c_out_vld, 1);
    chk("c_out_pd_next", c_out_pd, 8'h5C);
    chk("c_count_one", c_count, 1);
    @(negedge clk);
    c_out_rdy = 0;
    #1;
    chk("c_empty_after", c_out_vld, 0);
    chk("c_count_zero", c_count, 0);

    // Asynchronous reset while full, then stall-then-change protocol error.
    @(negedge clk);
    a_in_vld = 1; a_in_pd = 128'h11; a_out_rdy = 0;
    @(negedge clk);
    a_in_pd = 128'h12;
    @(negedge clk);
    a_in_pd = 128'h13;
    #1;
    chk("rst_pre_count", a_count, 2);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_count", a_count, 0);
    chk("rst_in_rdy", a_in_rdy, 1);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_out_vld_bypass", a_out_vld, 1);
    chk("rst_out_pd_bypass", a_out_pd, 128'h13);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    a_in_pd = 128'h14;
    @(negedge clk);
    a_in_pd = 128'h15;
    #1;
    chk("ovf_stall_in_rdy", a_in_rdy, 0);
    chk("ovf_before", a_ovf, 0);
    @(negedge clk);
    a_in_pd = 128'h16;
    #1;
    chk("ovf_not_yet", a_ovf, 0);
    @(negedge clk);
    a_in_vld = 0; a_out_rdy = 1;
    #1;
    chk("ovf_set", a_ovf, 1);
    @(negedge clk);
    #1;
    chk("ovf_sticky", a_ovf, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
